cpu_output_port: RTL and testbench

- Downstream stage of the CPU core. Captures each byte the CPU writes on its Output bus when an OUT strobe is given.
- Buffers the bytes in a small FIFO and hands them to a consumer (display/UART/bench monitor) over a valid/ready handshake.
- Tracks CPU Halt so the system can tell when the program has finished and all output has drained.
- Provides back-pressure (stall) and a sticky overflow flag for dropped writes.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/cpu_output_port_if.sv | 29 ++
 rtl/cpu_output_port_sync_fifo.sv | 47 ++++
 rtl/cpu_output_port.sv | 57 +++++
 tb/tb_cpu_output_port.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-core constants: bus width, state/IR field widths and the OUT opcode.
package cpu_pkg;
   localparam int DATA_W  = 8;
   localparam int STATE_W = 3;
   localparam int IR_W    = 3;

   typedef logic [IR_W-1:0]    opcode_t;
   typedef logic [STATE_W-1:0] state_t;

   // Upstream decodes this opcode to generate the one-cycle cpu_wr strobe.
   localparam opcode_t OP_OUT = 3'b110;
endpackage

// File: rtl/cpu_output_port_if.sv
// Bus bundle between the CPU/consumer side (master) and the output port (slave).
interface cpu_output_port_if
   import cpu_pkg::*;
#(
   parameter int DW    = cpu_pkg::DATA_W,
   parameter int PTR_W = 2
);
   logic [DW-1:0]  cpu_data;
   logic           cpu_wr;
   logic           cpu_halt;
   logic           stall;
   logic [DW-1:0]  out_data;
   logic           out_valid;
   logic           out_ready;
   logic [PTR_W:0] count;
   logic           overflow;
   logic [7:0]     wr_total;
   logic           done;

   modport master (
      output cpu_data, cpu_wr, cpu_halt, out_ready,
      input  stall, out_data, out_valid, count, overflow, wr_total, done
   );

   modport slave (
      input  cpu_data, cpu_wr, cpu_halt, out_ready,
      output stall, out_data, out_valid, count, overflow, wr_total, done
   );
endinterface

// File: rtl/cpu_output_port_sync_fifo.sv
// Register-array FIFO with wrapping pointers and an explicit occupancy count.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH == 2**PTR_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/cpu_output_port.sv
// CPU OUT-byte capture: buffers writes in sync_fifo, tracks overflow, write total and halt/done.
module cpu_output_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input logic              clk,
   input logic              rst,
   cpu_output_port_if.slave bus
);
   logic push;
   logic pop;
   logic full;
   logic empty;
   logic halt_seen;

   assign pop  = bus.out_valid & bus.out_ready;
   // A write into a full FIFO still lands when the head leaves in the same cycle.
   assign push = bus.cpu_wr & (~full | pop);

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (bus.cpu_data),
      .rdata (bus.out_data),
      .count (bus.count),
      .full  (full),
      .empty (empty)
   );

   assign bus.out_valid = ~empty;
   assign bus.stall     = full;
   assign bus.done      = halt_seen & empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.overflow <= 1'b0;
         bus.wr_total <= '0;
         halt_seen    <= 1'b0;
      end else begin
         if (bus.cpu_wr && !push)
            bus.overflow <= 1'b1;
         if (push)
            bus.wr_total <= bus.wr_total + 8'd1;
         if (bus.cpu_halt)
            halt_seen <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cpu_output_port.sv
// Directed bench for cpu_output_port: write, fill/overflow, full push+pop, wrap, halt, async reset.
module tb_cpu_output_port;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   cpu_output_port_if #(.DW(8), .PTR_W(2)) bus ();

   cpu_output_port #(.DATA_W(8), .DEPTH(4), .PTR_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] v);
      bus.cpu_data = v;
      bus.cpu_wr   = 1'b1;
      cyc();
      bus.cpu_wr   = 1'b0;
   endtask

   task automatic pop1();
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      bus.cpu_data  = '0;
      bus.cpu_wr    = 1'b0;
      bus.cpu_halt  = 1'b0;
      bus.out_ready = 1'b0;
      #13;
      chk("rst_count", int'(bus.count), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_stall", int'(bus.stall), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_data", int'(bus.out_data), 0);
      rst = 1'b0;
      cyc();

      // single write then pop
      wr(8'd5);
      chk("w1_count", int'(bus.count), 1);
      chk("w1_valid", int'(bus.out_valid), 1);
      chk("w1_data", int'(bus.out_data), 5);
      chk("w1_total", int'(bus.wr_total), 1);
      pop1();
      chk("p1_count", int'(bus.count), 0);
      chk("p1_valid", int'(bus.out_valid), 0);

      // fill, overflow, drain
      for (int i = 1; i <= 4; i++) wr(8'(i));
      chk("fill_stall", int'(bus.stall), 1);
      chk("fill_count", int'(bus.count), 4);
      chk("fill_ovf", int'(bus.overflow), 0);
      wr(8'd9);
      chk("ovf_flag", int'(bus.overflow), 1);
      chk("ovf_count", int'(bus.count), 4);
      chk("ovf_total", int'(bus.wr_total), 5);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_data", int'(bus.out_data), i);
         pop1();
      end
      chk("drain_count", int'(bus.count), 0);
      chk("drain_ovf_sticky", int'(bus.overflow), 1);

      // empty with write and ready both high: push only
      bus.cpu_data  = 8'hAA;
      bus.cpu_wr    = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      bus.cpu_wr    = 1'b0;
      bus.out_ready = 1'b0;
      chk("wr_rdy_count", int'(bus.count), 1);
      chk("wr_rdy_data", int'(bus.out_data), 8'hAA);
      pop1();
      async_reset();

      // full with simultaneous push and pop
      for (int i = 1; i <= 4; i++) wr(8'(i));
      bus.cpu_data  = 8'd7;
      bus.cpu_wr    = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      bus.cpu_wr    = 1'b0;
      bus.out_ready = 1'b0;
      chk("pp_count", int'(bus.count), 4);
      chk("pp_ovf", int'(bus.overflow), 0);
      chk("pp_total", int'(bus.wr_total), 5);
      chk("pp_d0", int'(bus.out_data), 2); pop1();
      chk("pp_d1", int'(bus.out_data), 3); pop1();
      chk("pp_d2", int'(bus.out_data), 4); pop1();
      chk("pp_d3", int'(bus.out_data), 7); pop1();
      chk("pp_empty", int'(bus.out_valid), 0);
      async_reset();

      // wrap-around through the pointers
      for (int i = 0; i < 10; i++) begin
         wr(8'(8'h10 + i));
         chk("wrap_count", int'(bus.count), 1);
         chk("wrap_data", int'(bus.out_data), 8'h10 + i);
         pop1();
      end
      chk("wrap_total", int'(bus.wr_total), 10);
      chk("wrap_empty", int'(bus.count), 0);

      // ready while empty is ignored
      pop1();
      chk("idle_count", int'(bus.count), 0);
      chk("idle_valid", int'(bus.out_valid), 0);

      // halt / done
      wr(8'd5);
      bus.cpu_halt = 1'b1;
      cyc();
      bus.cpu_halt = 1'b0;
      chk("halt_done0", int'(bus.done), 0);
      chk("halt_count", int'(bus.count), 1);
      pop1();
      chk("halt_done1", int'(bus.done), 1);
      wr(8'd6);
      chk("post_halt_done", int'(bus.done), 0);
      chk("post_halt_data", int'(bus.out_data), 6);
      pop1();
      chk("post_halt_done1", int'(bus.done), 1);

      // reset mid-stream with overflow set and 3 bytes buffered
      for (int i = 0; i < 5; i++) wr(8'(8'h20 + i));
      pop1();
      chk("mid_count", int'(bus.count), 3);
      chk("mid_ovf", int'(bus.overflow), 1);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #2;
      chk("ar_count", int'(bus.count), 0);
      chk("ar_valid", int'(bus.out_valid), 0);
      chk("ar_ovf", int'(bus.overflow), 0);
      chk("ar_total", int'(bus.wr_total), 0);
      chk("ar_done", int'(bus.done), 0);
      chk("ar_stall", int'(bus.stall), 0);
      rst = 1'b0;
      cyc();
      bus.out_ready = 1'b0;
      chk("ar_after_count", int'(bus.count), 0);
      chk("ar_after_done", int'(bus.done), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
